// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter: shares the PE memory port between MAC stores, x-vector cache
// loads and matrix decoder loads. Fixed priority with a starvation override, a
// write-pointer store address generator, load tag encoding, and an output queue
// that absorbs the registered memory stall.
// Optional build macro SPMV_ARB_PERF_EN adds 32-bit traffic/stall counters.
module spmv_mem_arbiter #(
  parameter int OUT_DEPTH    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [63:0] st_data,
  output logic        st_ready,
  input  logic        cache_valid,
  input  logic [47:0] cache_addr,
  output logic        cache_ready,
  input  logic        dec_valid,
  input  logic [47:0] dec_addr,
  input  logic [1:0]  dec_tag,
  output logic        dec_ready,
  input  logic        wp_load,
  input  logic [47:0] wp_base,
  input  logic [47:0] wp_end,
  output logic        req_mem_ld,
  output logic        req_mem_st,
  output logic [47:0] req_mem_addr,
  output logic [63:0] req_mem_d_or_tag,
  input  logic        req_mem_stall,
  output logic        idle
`ifdef SPMV_ARB_PERF_EN
  ,
  output logic [31:0] perf_st,
  output logic [31:0] perf_ld,
  output logic [31:0] perf_drop,
  output logic [31:0] perf_stall_cyc
`endif
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Two entries of slack cover the grant already in flight when the queue fills.
  localparam logic [CW-1:0] GRANT_MAX  = CW'(OUT_DEPTH - 3);
  localparam logic [CW-1:0] FULL_CNT   = CW'(OUT_DEPTH);

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [47:0] addr;
    logic [63:0] data;
  } q_ent_t;

  q_ent_t          q_mem [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   cache_starve, dec_starve;
  logic [47:0]     wp, wp_end_r;
  logic            stall_r;
  logic            grant_st, grant_c, grant_d;
  logic            st_live, enq, deq;
  q_ent_t          enq_ent;

  assign st_ready    = grant_st;
  assign cache_ready = grant_c;
  assign dec_ready   = grant_d;
  assign st_live     = grant_st && (wp != wp_end_r);
  assign enq         = st_live || grant_c || grant_d;
  assign deq         = (count != '0) && !stall_r;
  assign idle        = !st_valid && !cache_valid && !dec_valid && (count == '0)
                       && !req_mem_ld && !req_mem_st;

  // One grant per cycle: starved decoder, starved cache, then store > cache > decoder.
  always_comb begin
    grant_st = 1'b0;
    grant_c  = 1'b0;
    grant_d  = 1'b0;
    if (!rst && (count <= GRANT_MAX)) begin
      if (dec_valid && (dec_starve == STARVE_MAX))          grant_d  = 1'b1;
      else if (cache_valid && (cache_starve == STARVE_MAX)) grant_c  = 1'b1;
      else if (st_valid)                                    grant_st = 1'b1;
      else if (cache_valid)                                 grant_c  = 1'b1;
      else if (dec_valid)                                   grant_d  = 1'b1;
    end
  end

  // Build the queue entry for the granted requester; loads carry their response tag.
  always_comb begin
    enq_ent = '0;
    if (st_live) begin
      enq_ent.st   = 1'b1;
      enq_ent.addr = wp;
      enq_ent.data = st_data;
    end else if (grant_c) begin
      enq_ent.ld   = 1'b1;
      enq_ent.addr = cache_addr;
      enq_ent.data = 64'h1;
    end else if (grant_d) begin
      enq_ent.ld   = 1'b1;
      enq_ent.addr = dec_addr;
      enq_ent.data = {61'b0, dec_tag, 1'b0};
    end
  end

  // Starvation counters: count passed-over cycles, saturate, clear on own grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_starve <= '0;
      dec_starve   <= '0;
    end else begin
      if (grant_c)                                        cache_starve <= '0;
      else if (cache_valid && (cache_starve != STARVE_MAX)) cache_starve <= cache_starve + SW'(1);
      if (grant_d)                                        dec_starve <= '0;
      else if (dec_valid && (dec_starve != STARVE_MAX))   dec_starve <= dec_starve + SW'(1);
    end
  end

  // Store write pointer; a reload overrides the increment of a same-cycle store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      wp_end_r <= '0;
    end else if (wp_load) begin
      wp       <= wp_base;
      wp_end_r <= wp_end;
    end else if (st_live) begin
      wp       <= wp + 48'd8;
    end
  end

  // Queue storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (enq) q_mem[wr_ptr] <= enq_ent;
  end

  // Queue pointers, occupancy and the registered stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall_r <= 1'b0;
    end else begin
      stall_r <= req_mem_stall;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Memory port register stage: strobes pulse once per dequeued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_mem_ld       <= 1'b0;
      req_mem_st       <= 1'b0;
      req_mem_addr     <= '0;
      req_mem_d_or_tag <= '0;
    end else if (deq) begin
      req_mem_ld       <= q_mem[rd_ptr].ld;
      req_mem_st       <= q_mem[rd_ptr].st;
      req_mem_addr     <= q_mem[rd_ptr].addr;
      req_mem_d_or_tag <= q_mem[rd_ptr].data;
    end else begin
      req_mem_ld       <= 1'b0;
      req_mem_st       <= 1'b0;
    end
  end

  // The grant slack should make a full-queue write impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(enq && (count == FULL_CNT)))
    else $error("spmv_mem_arbiter: enqueue into full output queue");

`ifdef SPMV_ARB_PERF_EN
  // Traffic and stall counters, cleared with each new store window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_st        <= '0;
      perf_ld        <= '0;
      perf_drop      <= '0;
      perf_stall_cyc <= '0;
    end else if (wp_load) begin
      perf_st        <= '0;
      perf_ld        <= '0;
      perf_drop      <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (st_live)                       perf_st        <= perf_st + 32'd1;
      if (grant_c || grant_d)            perf_ld        <= perf_ld + 32'd1;
      if (grant_st && !st_live)          perf_drop      <= perf_drop + 32'd1;
      if (stall_r && (count != '0))      perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Self-checking bench for spmv_mem_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_spmv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, cache_valid, dec_valid, wp_load, req_mem_stall;
  logic [63:0] st_data;
  logic [47:0] cache_addr, dec_addr, wp_base, wp_end;
  logic [1:0]  dec_tag;
  logic        st_ready, cache_ready, dec_ready, req_mem_ld, req_mem_st, idle;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;

  always #5 clk = ~clk;

  spmv_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_data(st_data), .st_ready(st_ready),
    .cache_valid(cache_valid), .cache_addr(cache_addr), .cache_ready(cache_ready),
    .dec_valid(dec_valid), .dec_addr(dec_addr), .dec_tag(dec_tag), .dec_ready(dec_ready),
    .wp_load(wp_load), .wp_base(wp_base), .wp_end(wp_end),
    .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
    .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall), .idle(idle)
  );

  typedef struct {
    bit          ld;
    bit          st;
    logic [47:0] addr;
    logic [63:0] data;
  } ent_t;

  // Behavioural model state
  ent_t        mq[$];
  bit          m_stall, m_ld, m_st;
  logic [47:0] m_addr, m_wp, m_wpe;
  logic [63:0] m_data;
  int          m_cs, m_ds;

  int n_chk = 0;
  int n_fail = 0;
  bit obs_st, obs_c, obs_d;
  int st_strobes = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall = 0; m_ld = 0; m_st = 0;
    m_addr = '0; m_data = '0; m_wp = '0; m_wpe = '0;
    m_cs = 0; m_ds = 0;
  endtask

  task automatic clear_inputs();
    st_valid = 0; cache_valid = 0; dec_valid = 0; wp_load = 0; req_mem_stall = 0;
    st_data = '0; cache_addr = '0; dec_addr = '0; dec_tag = '0; wp_base = '0; wp_end = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    int   gsel;
    ent_t e;
    @(negedge clk);
    if (rst) model_reset();
    gsel = 0;
    if (!rst && mq.size() <= 13) begin
      if (dec_valid && m_ds == 8)        gsel = 3;
      else if (cache_valid && m_cs == 8) gsel = 2;
      else if (st_valid)                 gsel = 1;
      else if (cache_valid)              gsel = 2;
      else if (dec_valid)                gsel = 3;
    end
    chk("st_ready", st_ready, gsel == 1);
    chk("cache_ready", cache_ready, gsel == 2);
    chk("dec_ready", dec_ready, gsel == 3);
    chk("req_mem_ld", req_mem_ld, m_ld);
    chk("req_mem_st", req_mem_st, m_st);
    if (m_ld || m_st || rst) begin
      chk("req_mem_addr", req_mem_addr, m_addr);
      chk("req_mem_d_or_tag", req_mem_d_or_tag, m_data);
    end
    chk("idle", idle, !st_valid && !cache_valid && !dec_valid && mq.size() == 0 && !m_ld && !m_st);
    obs_st = st_ready; obs_c = cache_ready; obs_d = dec_ready;
    if (req_mem_st) st_strobes++;
    if (!rst) begin
      if (mq.size() > 0 && !m_stall) begin
        e = mq.pop_front();
        m_ld = e.ld; m_st = e.st; m_addr = e.addr; m_data = e.data;
      end else begin
        m_ld = 0; m_st = 0;
      end
      case (gsel)
        1: if (m_wp != m_wpe) begin
             mq.push_back('{ld: 1'b0, st: 1'b1, addr: m_wp, data: st_data});
             m_wp = m_wp + 48'd8;
           end
        2: mq.push_back('{ld: 1'b1, st: 1'b0, addr: cache_addr, data: 64'd1});
        3: mq.push_back('{ld: 1'b1, st: 1'b0, addr: dec_addr, data: 64'(dec_tag) * 2});
        default: ;
      endcase
      if (wp_load) begin
        m_wp = wp_base; m_wpe = wp_end;
      end
      if (gsel == 2) m_cs = 0; else if (cache_valid && m_cs < 8) m_cs++;
      if (gsel == 3) m_ds = 0; else if (dec_valid && m_ds < 8) m_ds++;
      m_stall = req_mem_stall;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    clear_inputs();
    repeat (n) step();
  endtask

  initial begin
    int first_c, grants, accepted, base_strobes, cyc;
    clear_inputs();
    model_reset();
    rst = 1;
    repeat (2) step();
    rst = 0;
    step();

    // 1: store window of two slots, third store dropped
    wp_load = 1; wp_base = 48'h1000; wp_end = 48'h1010;
    step();
    wp_load = 0;
    base_strobes = st_strobes;
    accepted = 0;
    for (int i = 0; i < 10 && accepted < 3; i++) begin
      st_valid = 1; st_data = 64'hD0 + 64'(accepted);
      step();
      if (obs_st) accepted++;
    end
    chk("t1_accepted", accepted, 3);
    drain(6);
    chk("t1_store_strobes", st_strobes - base_strobes, 2);

    // 2: all three requesters at once
    wp_load = 1; wp_base = 48'h2000; wp_end = 48'h3000;
    step();
    wp_load = 0;
    st_valid = 1; st_data = 64'hABCD; cache_valid = 1; cache_addr = 48'h500;
    dec_valid = 1; dec_addr = 48'h600; dec_tag = 2'd3;
    step();
    st_valid = 0;
    step();
    cache_valid = 0;
    step();
    drain(6);

    // 3: store held with cache waiting; cache forced in after 8 passed-over cycles
    first_c = -1;
    st_valid = 1; cache_valid = 1; cache_addr = 48'h700;
    for (int i = 0; i < 20; i++) begin
      st_data = 64'(i);
      step();
      if (obs_c && first_c < 0) first_c = i;
    end
    chk("t3_first_cache_grant", first_c, 8);
    drain(6);

    // 4: stall for 10 cycles while decoder loads flow
    for (int i = 0; i < 30; i++) begin
      dec_valid = 1; dec_addr = 48'(i * 16); dec_tag = 2'(i);
      req_mem_stall = (i >= 10 && i < 20);
      step();
    end
    drain(20);

    // 5: flood of 32 loads with stall held, then release
    grants = 0; accepted = 0;
    req_mem_stall = 1; cache_valid = 1; cache_addr = 48'h8000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_c) begin grants++; accepted++; cache_addr = 48'h8000 + 48'(accepted * 8); end
    end
    chk("t5_grants_under_stall", grants, 14);
    req_mem_stall = 0;
    cyc = 0;
    while (accepted < 32 && cyc < 200) begin
      step();
      cyc++;
      if (obs_c) begin accepted++; cache_addr = 48'h8000 + 48'(accepted * 8); end
    end
    chk("t5_accepted", accepted, 32);
    drain(40);

    // 6: reset mid-burst, then wp_load together with a store
    cache_valid = 1;
    for (int i = 0; i < 6; i++) begin cache_addr = 48'(i); step(); end
    clear_inputs();
    rst = 1;
    step();
    chk("t6_idle_in_reset", idle, 1);
    rst = 0;
    step();
    wp_load = 1; wp_base = 48'h4000; wp_end = 48'h4040; st_valid = 1; st_data = 64'h55;
    step();
    wp_load = 0; st_data = 64'h66;
    step();
    drain(6);

    // Random traffic with stall bursts and window reloads
    for (int i = 0; i < 500; i++) begin
      st_valid    = ($urandom_range(0, 2) == 0);
      st_data     = {$urandom, $urandom};
      cache_valid = ($urandom_range(0, 1) == 1);
      cache_addr  = {16'($urandom), $urandom};
      dec_valid   = ($urandom_range(0, 1) == 1);
      dec_addr    = {16'($urandom), $urandom};
      dec_tag     = 2'($urandom);
      req_mem_stall = ((i / 40) % 3 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      wp_load     = ($urandom_range(0, 24) == 0);
      wp_base     = {16'($urandom), $urandom} & ~48'h7;
      wp_end      = wp_base + 48'(8 * $urandom_range(0, 6));
      step();
    end
    drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
